// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and default widths for the two-requester ALU issue controller.
package alu_ctrl_pkg;

    localparam int DEF_W   = 8;
    localparam int DEF_OPW = 4;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, issue and response bundle shared by the requesters, the issue controller and the ALU core.
interface alu_issue_ctrl_if
    import alu_ctrl_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int OPW = DEF_OPW
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2*OPW-1:0] req_op;
    logic [2*W-1:0]   req_a;
    logic [2*W-1:0]   req_b;
    logic             alu_valid;
    logic [OPW-1:0]   alu_op;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [W-1:0]     alu_result;
    logic [1:0]       rsp_valid;
    logic [W-1:0]     rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result,
        input  req_ready, alu_valid, alu_op, alu_a, alu_b, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result,
        output req_ready, alu_valid, alu_op, alu_a, alu_b, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_issue_ctrl_arbiter.sv
// Two-way grant for alu_issue_ctrl. Macro ALU_ISSUE_RR_EN selects round-robin with a
// priority pointer; otherwise requester 0 has fixed priority and no pointer is built.
module alu_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);
`ifdef ALU_ISSUE_RR_EN
    logic ptr_q;
    logic ptr_d;

    // ptr_q set means requester 1 is favoured on the next contention
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (grant[0]) begin
            ptr_d = 1'b1;
        end else if (grant[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign grant          = {req[1] & ~req[0], req[0]};
`endif
endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one pipelined ALU between two requesters, tagging each issue so its result returns
// to the right requester. Macro ALU_ISSUE_RR_EN enables round-robin arbitration.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int OPW     = DEF_OPW,
    parameter int ALU_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    alu_issue_ctrl_if.slave              bus,
    input  logic                         flush,
    output logic                         flush_done,
    output logic                         busy,
    output logic [$clog2(ALU_LAT+3)-1:0] inflight
);
    localparam int CW = $clog2(ALU_LAT + 3);

    state_e         state_q, state_d;
    logic           alu_valid_q, alu_valid_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic [1:0]     rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           flush_done_q, flush_done_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    tag_t           tag_q [ALU_LAT+1];
    tag_t           tag_d [ALU_LAT+1];

    logic       can_issue;
    logic [1:0] arb_req;
    logic [1:0] grant;
    logic       acc;
    logic       sel;

    assign can_issue = (state_q == RUN) && !flush && !rst;
    assign arb_req   = bus.req_valid & {2{can_issue}};

    alu_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (arb_req),
        .grant (grant)
    );

    assign acc = |grant;
    assign sel = grant[1];

    // tag_q[ALU_LAT] lines up with the cycle in which alu_result carries that issue's result
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if (inflight_q == '0) state_d = DONE;
            default: state_d = RUN;
        endcase

        alu_valid_d = acc;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        if (acc) begin
            alu_op_d = bus.req_op[int'(sel)*OPW +: OPW];
            alu_a_d  = bus.req_a[int'(sel)*W +: W];
            alu_b_d  = bus.req_b[int'(sel)*W +: W];
        end

        tag_d[0] = '{vld: acc, id: sel};
        for (int k = 1; k <= ALU_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        rsp_valid_d = 2'b00;
        rsp_data_d  = rsp_data_q;
        if (tag_q[ALU_LAT].vld) begin
            rsp_valid_d[tag_q[ALU_LAT].id] = 1'b1;
            rsp_data_d                     = bus.alu_result;
        end

        inflight_d   = inflight_q + CW'(acc) - CW'(|rsp_valid_q);
        flush_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            alu_valid_q  <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
            flush_done_q <= 1'b0;
            inflight_q   <= '0;
            tag_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            alu_valid_q  <= alu_valid_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            flush_done_q <= flush_done_d;
            inflight_q   <= inflight_d;
            tag_q        <= tag_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.alu_valid = alu_valid_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign flush_done    = flush_done_q;
    assign inflight      = inflight_q;
    assign busy          = (inflight_q != '0) || (state_q != RUN);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: arbitration vector table, directed corner sequences and a random
// run, all scored against a transaction-level model of grants, responses and drain.
module tb_alu_issue_ctrl;
    localparam int W       = 8;
    localparam int OPW     = 4;
    localparam int ALU_LAT = 2;
    localparam int CW      = $clog2(ALU_LAT + 3);
`ifdef ALU_ISSUE_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct {
        int           due;
        logic [1:0]   onehot;
        logic [W-1:0] data;
    } rsp_t;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] ready_rr;
        logic [1:0] ready_fix;
    } vec_t;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          flush = 1'b0;
    logic          flush_done;
    logic          busy;
    logic [CW-1:0] inflight;

    alu_issue_ctrl_if #(.W(W), .OPW(OPW)) bus ();

    alu_issue_ctrl #(.W(W), .OPW(OPW), .ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy),
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        return (a + b) ^ {op, op};
    endfunction

    // Stand-in ALU core: result appears ALU_LAT cycles after alu_valid, junk otherwise
    logic [W-1:0] alu_line [ALU_LAT] = '{default: '0};
    always @(negedge clk) begin
        bus.alu_result <= alu_line[ALU_LAT-1];
        for (int k = ALU_LAT - 1; k > 0; k--) alu_line[k] <= alu_line[k-1];
        alu_line[0] <= bus.alu_valid ? alu_fn(bus.alu_op, bus.alu_a, bus.alu_b) : W'($urandom);
    end

    int             checks = 0;
    int             fails  = 0;
    int             cyc    = 0;
    rsp_t           rsp_q[$];
    bit             exp_alu_valid = 1'b0;
    logic [OPW-1:0] exp_op = '0;
    logic [W-1:0]   exp_a  = '0;
    logic [W-1:0]   exp_b  = '0;
    bit             favour1  = 1'b0;
    bit             draining = 1'b0;
    int             done_cycle = -1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One clock cycle: score registered outputs, drive inputs, score req_ready, advance the model
    task automatic applyStimulus(input logic [1:0] v, input logic fl, input logic r,
                                 input logic [2*OPW-1:0] op, input logic [2*W-1:0] a,
                                 input logic [2*W-1:0] b);
        logic [1:0] exp_rsp;
        logic [1:0] exp_ready;
        int         exp_infl;
        bit         allow;
        int         id;
        @(negedge clk);
        exp_infl = rsp_q.size();
        exp_rsp  = 2'b00;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) exp_rsp = rsp_q[0].onehot;
        checkOutput("rsp_valid", bus.rsp_valid, exp_rsp);
        if (exp_rsp != 2'b00) begin
            checkOutput("rsp_data", bus.rsp_data, rsp_q[0].data);
            void'(rsp_q.pop_front());
        end
        checkOutput("alu_valid", bus.alu_valid, exp_alu_valid);
        if (exp_alu_valid) begin
            checkOutput("alu_op", bus.alu_op, exp_op);
            checkOutput("alu_a", bus.alu_a, exp_a);
            checkOutput("alu_b", bus.alu_b, exp_b);
        end
        checkOutput("inflight", inflight, exp_infl);
        checkOutput("flush_done", flush_done, cyc == done_cycle);
        checkOutput("busy", busy, exp_infl != 0 || draining || cyc == done_cycle);

        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        flush         = fl;
        rst           = r;
        #1;
        allow     = !r && !fl && !draining && cyc != done_cycle;
        exp_ready = 2'b00;
        if (allow) begin
            exp_ready = v;
            if (v == 2'b11) exp_ready = (RR_EN && favour1) ? 2'b10 : 2'b01;
        end
        checkOutput("req_ready", bus.req_ready, exp_ready);

        if (r) begin
            rsp_q.delete();
            exp_alu_valid = 1'b0;
            favour1       = 1'b0;
            draining      = 1'b0;
            done_cycle    = -1;
        end else begin
            exp_alu_valid = (exp_ready != 2'b00);
            if (exp_alu_valid) begin
                id     = exp_ready[1] ? 1 : 0;
                exp_op = op[id*OPW +: OPW];
                exp_a  = a[id*W +: W];
                exp_b  = b[id*W +: W];
                rsp_q.push_back('{due: cyc + ALU_LAT + 2, onehot: exp_ready,
                                  data: alu_fn(exp_op, exp_a, exp_b)});
                favour1 = (id == 0);
            end
            if (draining) begin
                if (exp_infl == 0) begin
                    draining   = 1'b0;
                    done_cycle = cyc + 1;
                end
            end else if (fl && cyc != done_cycle) begin
                draining = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic doReset();
        applyStimulus(2'b11, 1'b0, 1'b1, '0, '0, '0);
        checkOutput("ready_in_reset", bus.req_ready, 2'b00);
    endtask

    vec_t       vecs [10];
    logic [1:0] cont_rr  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int         fl_infl  [6] = '{3, 2, 1, 0, 0, 0};
    logic       fl_done  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] fl_ready [6];

    initial begin
        logic [1:0]       rv;
        logic [2*OPW-1:0] rop;
        logic [2*W-1:0]   ra;
        logic [2*W-1:0]   rb;
        logic             rfl;

        vecs[0] = '{2'b01, 2'b01, 2'b01};
        vecs[1] = '{2'b11, 2'b10, 2'b01};
        vecs[2] = '{2'b11, 2'b01, 2'b01};
        vecs[3] = '{2'b10, 2'b10, 2'b10};
        vecs[4] = '{2'b11, 2'b01, 2'b01};
        vecs[5] = '{2'b00, 2'b00, 2'b00};
        vecs[6] = '{2'b11, 2'b10, 2'b01};
        vecs[7] = '{2'b01, 2'b01, 2'b01};
        vecs[8] = '{2'b01, 2'b01, 2'b01};
        vecs[9] = '{2'b11, 2'b10, 2'b01};
        fl_ready = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, RR_EN ? 2'b10 : 2'b01};

        bus.req_valid = 2'b00;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        // Reset values
        doReset();
        idle(1);
        checkOutput("reset_alu_op", bus.alu_op, 0);
        checkOutput("reset_alu_a", bus.alu_a, 0);
        checkOutput("reset_alu_b", bus.alu_b, 0);
        checkOutput("reset_rsp_data", bus.rsp_data, 0);

        // Single request from requester 0
        applyStimulus(2'b01, 1'b0, 1'b0, 8'h03, 16'h0012, 16'h0034);
        checkOutput("single_ready", bus.req_ready, 2'b01);
        idle(1);
        checkOutput("single_alu_valid", bus.alu_valid, 1);
        checkOutput("single_alu_op", bus.alu_op, 4'h3);
        checkOutput("single_alu_a", bus.alu_a, 8'h12);
        checkOutput("single_alu_b", bus.alu_b, 8'h34);
        idle(2);
        checkOutput("single_rsp_early", bus.rsp_valid, 2'b00);
        idle(1);
        checkOutput("single_rsp_valid", bus.rsp_valid, 2'b01);
        checkOutput("single_rsp_data", bus.rsp_data, 8'h75);
        idle(2);

        // Arbitration vector table
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].valid, 1'b0, 1'b0, {4'(i + 7), 4'(i)},
                          {8'(i * 5 + 1), 8'(i * 3)}, {8'(i + 100), 8'(i * 11)});
            checkOutput($sformatf("vec%0d_ready", i), bus.req_ready,
                        RR_EN ? vecs[i].ready_rr : vecs[i].ready_fix);
        end
        idle(6);

        // Contention for 4 cycles
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 1'b0, 1'b0, {4'(9 - i), 4'(i)}, {8'(8'h40 + i), 8'(8'h10 + i)},
                          {8'(8'h50 + i), 8'(8'h20 + i)});
            checkOutput($sformatf("contend%0d_ready", i), bus.req_ready,
                        RR_EN ? cont_rr[i] : 2'b01);
        end
        idle(6);

        // Flush with 3 in flight
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, 1'b0, 1'b0, 8'(i + 1), 16'(i + 2), 16'(i + 3));
        applyStimulus(2'b11, 1'b1, 1'b0, 8'h21, 16'h0505, 16'h0606);
        checkOutput("flush_ready", bus.req_ready, 2'b00);
        checkOutput("flush_inflight", inflight, 3);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b11, 1'b0, 1'b0, 8'h44, 16'h0a0b, 16'h0c0d);
            checkOutput($sformatf("drain%0d_inflight", i), inflight, fl_infl[i]);
            checkOutput($sformatf("drain%0d_done", i), flush_done, fl_done[i]);
            checkOutput($sformatf("drain%0d_ready", i), bus.req_ready, fl_ready[i]);
        end
        idle(6);

        // Accept and response in the same cycle
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b01, 1'b0, 1'b0, 8'(i), 16'(i * 7), 16'(i * 9));
            if (i >= 4) begin
                checkOutput($sformatf("overlap%0d_inflight", i), inflight, 4);
                checkOutput($sformatf("overlap%0d_busy", i), busy, 1);
            end
        end
        idle(6);

        // Reset with 2 in flight
        doReset();
        applyStimulus(2'b01, 1'b0, 1'b0, 8'h05, 16'h0011, 16'h0022);
        applyStimulus(2'b01, 1'b0, 1'b0, 8'h06, 16'h0033, 16'h0044);
        applyStimulus(2'b11, 1'b0, 1'b1, 8'h77, 16'h5555, 16'h6666);
        checkOutput("rst_mid_ready", bus.req_ready, 2'b00);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            checkOutput("rst_mid_rsp_valid", bus.rsp_valid, 2'b00);
            checkOutput("rst_mid_rsp_data", bus.rsp_data, 0);
            checkOutput("rst_mid_alu_valid", bus.alu_valid, 0);
            checkOutput("rst_mid_alu_op", bus.alu_op, 0);
            checkOutput("rst_mid_alu_a", bus.alu_a, 0);
            checkOutput("rst_mid_inflight", inflight, 0);
            checkOutput("rst_mid_busy", busy, 0);
            checkOutput("rst_mid_flush_done", flush_done, 0);
        end

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            rv  = 2'($urandom);
            rop = (2*OPW)'($urandom);
            ra  = (2*W)'($urandom);
            rb  = (2*W)'($urandom);
            rfl = ($urandom_range(0, 19) == 0);
            applyStimulus(rv, rfl, 1'b0, rop, ra, rb);
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] time limit reached");
    end
endmodule
